rcv_bit_timer: RTL and testbench

- USB full-speed receive bit timer. Sits directly downstream of the edge detector and consumes its single-cycle `d_edge` pulse.
- Recovers bit timing from transitions on the differential pair. Emits a mid-bit `shift_enable` strobe to the NRZI decoder and shift register, and a `byte_received` strobe every 8 bits.
- Flags loss of transitions (bit-stuffing violation or stalled line) so the RX controller can abort the packet.

---
 rtl/usb_rx_pkg.sv | 21 ++
 rtl/rx_flex_counter.sv | 52 +++++
 rtl/rcv_bit_timer.sv | 135 +++++++++++++
 tb/tb_rcv_bit_timer.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_rx_pkg.sv
// ---------------------------------------------------------------------------
// usb_rx_pkg
// Shared definitions for the USB full-speed receive path.
//   rcv_timer_state_t : bit timer FSM states (IDLE, RUN, ERR), 2-bit encoded
//   USB_CLKS_PER_BIT  : system clocks per USB bit (96 MHz / 12 Mbps)
//   USB_BITS_PER_BYTE : sampled bits per received byte
//   USB_MAX_IDLE_BITS : longest legal run of bit times without a transition
// ---------------------------------------------------------------------------
package usb_rx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        ERR  = 2'd2
    } rcv_timer_state_t;

    localparam int USB_CLKS_PER_BIT  = 8;
    localparam int USB_BITS_PER_BYTE = 8;
    localparam int USB_MAX_IDLE_BITS = 7;

endpackage

// File: rtl/rx_flex_counter.sv
// ---------------------------------------------------------------------------
// rx_flex_counter
// Up-counter with synchronous clear, synchronous load, count enable and a
// programmable rollover value. After reaching rollover_val the count wraps
// to 0 and rollover_flag is raised for exactly the following cycle.
//   clk, n_rst     : clock, asynchronous active-low reset
//   clear          : synchronous clear of count and flag (highest priority)
//   load, load_val : synchronous load of count (clears the flag)
//   count_enable   : advance the count this cycle
//   rollover_val   : last value before wrapping to 0
//   count          : current count
//   rollover_flag  : registered one-cycle wrap indication
// ---------------------------------------------------------------------------
module rx_flex_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             count_enable,
    input  logic [WIDTH-1:0] rollover_val,
    output logic [WIDTH-1:0] count,
    output logic             rollover_flag
);

    // Clear beats load beats count; the flag is only ever raised by a wrap.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count         <= '0;
            rollover_flag <= 1'b0;
        end else if (clear) begin
            count         <= '0;
            rollover_flag <= 1'b0;
        end else if (load) begin
            count         <= load_val;
            rollover_flag <= 1'b0;
        end else if (count_enable) begin
            if (count == rollover_val) begin
                count         <= '0;
                rollover_flag <= 1'b1;
            end else begin
                count         <= count + 1'b1;
                rollover_flag <= 1'b0;
            end
        end else begin
            rollover_flag <= 1'b0;
        end
    end

endmodule

// File: rtl/rcv_bit_timer.sv
// ---------------------------------------------------------------------------
// rcv_bit_timer
// USB full-speed receive bit timer. Starts on the first transition while
// enable_timer is high, strobes shift_enable at the sample point of every
// bit, strobes byte_received after every BITS_PER_BYTE bits and raises
// rx_error when no transition is seen for more than MAX_IDLE_BITS bits.
//   clk, n_rst    : clock, asynchronous active-low reset
//   d_edge        : one-cycle pulse per transition on D+/D-
//   enable_timer  : high while a packet is being received
//   shift_enable  : one-cycle strobe, sample the current bit
//   byte_received : one-cycle strobe, a full byte has been shifted
//   rx_error      : transition timeout, held until enable_timer drops
//   bit_cnt       : bits shifted into the current byte
// Build option: define RCV_TIMER_RESYNC_EN to re-align the bit phase on
// every transition; without it the phase free-runs after the start edge.
// ---------------------------------------------------------------------------
module rcv_bit_timer
    import usb_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT  = USB_CLKS_PER_BIT,
    parameter int SAMPLE_POINT  = 3,
    parameter int BITS_PER_BYTE = USB_BITS_PER_BYTE,
    parameter int MAX_IDLE_BITS = USB_MAX_IDLE_BITS
) (
    input  logic                             clk,
    input  logic                             n_rst,
    input  logic                             d_edge,
    input  logic                             enable_timer,
    output logic                             shift_enable,
    output logic                             byte_received,
    output logic                             rx_error,
    output logic [$clog2(BITS_PER_BYTE)-1:0] bit_cnt
);

    localparam int PHASE_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W   = $clog2(BITS_PER_BYTE);
    localparam int IDLE_W  = $clog2(MAX_IDLE_BITS + 1);

    localparam logic [PHASE_W-1:0] SAMPLE_PHASE = PHASE_W'(SAMPLE_POINT);
    localparam logic [PHASE_W-1:0] LAST_PHASE   = PHASE_W'(CLKS_PER_BIT - 1);
    localparam logic [PHASE_W-1:0] EDGE_PHASE   = PHASE_W'(1);
    localparam logic [BIT_W-1:0]   LAST_BIT     = BIT_W'(BITS_PER_BYTE - 1);
    localparam logic [IDLE_W-1:0]  IDLE_MAX     = IDLE_W'(MAX_IDLE_BITS);

`ifdef RCV_TIMER_RESYNC_EN
    localparam bit RESYNC = 1'b1;
`else
    localparam bit RESYNC = 1'b0;
`endif

    rcv_timer_state_t   state;
    logic [PHASE_W-1:0] phase;
    logic [IDLE_W-1:0]  idle_cnt;
    logic               start;
    logic               timeout;
    logic               phase_clear;
    logic               phase_load;
    logic               bit_clear;
    logic               phase_wrap_unused;

    assign start        = (state == IDLE) && enable_timer && d_edge;
    assign shift_enable = (state == RUN) && (phase == SAMPLE_PHASE);
    assign timeout      = shift_enable && (idle_cnt == IDLE_MAX);
    assign rx_error     = (state == ERR);

    // The start edge is phase 0, so the phase is loaded with 1 for the next
    // cycle; with resync every later edge re-anchors the bit the same way.
    assign phase_clear = !enable_timer || ((state == IDLE) && !start);
    assign phase_load  = start || (RESYNC && (state == RUN) && d_edge);
    assign bit_clear   = !enable_timer || (state == IDLE);

    rx_flex_counter #(
        .WIDTH (PHASE_W)
    ) u_phase_cnt (
        .clk           (clk),
        .n_rst         (n_rst),
        .clear         (phase_clear),
        .load          (phase_load),
        .load_val      (EDGE_PHASE),
        .count_enable  (state == RUN),
        .rollover_val  (LAST_PHASE),
        .count         (phase),
        .rollover_flag (phase_wrap_unused)
    );

    // The strobe that trips the timeout is not counted as a bit, so it can
    // never produce byte_received; the wrap flag doubles as byte_received.
    rx_flex_counter #(
        .WIDTH (BIT_W)
    ) u_bit_cnt (
        .clk           (clk),
        .n_rst         (n_rst),
        .clear         (bit_clear),
        .load          (1'b0),
        .load_val      ('0),
        .count_enable  (shift_enable && !timeout),
        .rollover_val  (LAST_BIT),
        .count         (bit_cnt),
        .rollover_flag (byte_received)
    );

    // Bits sampled since the last transition; saturates at the limit and a
    // transition in the same cycle as a strobe wins.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            idle_cnt <= '0;
        end else if (!enable_timer || (state == IDLE)) begin
            idle_cnt <= '0;
        end else if (state == RUN) begin
            if (d_edge) begin
                idle_cnt <= '0;
            end else if (shift_enable && (idle_cnt != IDLE_MAX)) begin
                idle_cnt <= idle_cnt + 1'b1;
            end
        end
    end

    // Dropping enable_timer returns to IDLE from anywhere; ERR is left only
    // that way.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else if (!enable_timer) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (d_edge)  state <= RUN;
                RUN:     if (timeout) state <= ERR;
                ERR:     state <= ERR;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rcv_bit_timer.sv
// ---------------------------------------------------------------------------
// tb_rcv_bit_timer
// Self-checking bench for rcv_bit_timer: a short table of vectors, directed
// multi-cycle sequences and a randomized run against a timing model that
// derives the bit phase from the number of cycles since the last anchoring
// edge. Honours RCV_TIMER_RESYNC_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_rcv_bit_timer;

    localparam int CLKS   = 8;
    localparam int SAMPLE = 3;
    localparam int BPB    = 8;
    localparam int MAXI   = 7;

`ifdef RCV_TIMER_RESYNC_EN
    localparam bit RESYNC = 1'b1;
`else
    localparam bit RESYNC = 1'b0;
`endif

    logic       clk;
    logic       n_rst;
    logic       d_edge;
    logic       enable_timer;
    logic       shift_enable;
    logic       byte_received;
    logic       rx_error;
    logic [2:0] bit_cnt;

    rcv_bit_timer dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .d_edge        (d_edge),
        .enable_timer  (enable_timer),
        .shift_enable  (shift_enable),
        .byte_received (byte_received),
        .rx_error      (rx_error),
        .bit_cnt       (bit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int assert_count = 0;
    int fail_count   = 0;

    // Reference model: 0 idle, 1 running, 2 error
    int m_state;
    int m_age;
    int m_bits;
    int m_idle;
    int m_pend;

    int obs_shift, obs_byte, obs_err, obs_bitcnt;
    int cycle_no = 0;
    int seq_base = 0;
    int strobe_log[$];
    int byte_log[$];

    typedef struct {
        bit en;
        bit edge_in;
        int exp_shift;
        int exp_byte;
        int exp_err;
        int exp_bitcnt;
    } vec_t;

    vec_t vecs[14];

    task automatic checkOutput(input string name, input int act, input int exp);
        assert_count++;
        if (act !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic checkLog(input string name, input int act[$], input int exp[$]);
        checkOutput({name, " count"}, act.size(), exp.size());
        for (int i = 0; i < act.size() && i < exp.size(); i++)
            checkOutput({name, " cycle"}, act[i], exp[i]);
    endtask

    task automatic resetModel();
        m_state = 0;
        m_age   = 0;
        m_bits  = 0;
        m_idle  = 0;
        m_pend  = 0;
    endtask

    function automatic int modelShift();
        return ((m_state == 1) && ((m_age % CLKS) == SAMPLE)) ? 1 : 0;
    endfunction

    task automatic modelStep(input bit en, input bit edge_in);
        int strobe;
        int tmo;
        if (!n_rst || !en) begin
            resetModel();
        end else if (m_state == 0) begin
            m_pend = 0;
            if (edge_in) begin
                m_state = 1;
                m_age   = 1;
                m_bits  = 0;
                m_idle  = 0;
            end
        end else if (m_state == 1) begin
            strobe = modelShift();
            tmo    = (strobe == 1 && m_idle == MAXI) ? 1 : 0;
            m_pend = 0;
            if (strobe == 1 && tmo == 0) begin
                m_bits++;
                if (m_bits == BPB) begin
                    m_bits = 0;
                    m_pend = 1;
                end
            end
            if (edge_in) m_idle = 0;
            else if (strobe == 1 && m_idle < MAXI) m_idle++;
            if (RESYNC && edge_in) m_age = 1;
            else m_age++;
            if (tmo == 1) m_state = 2;
        end else begin
            m_pend = 0;
        end
    endtask

    // One clock: observe at the falling edge, compare with the model, then
    // drive the inputs for the coming rising edge.
    task automatic applyStimulus(input bit en, input bit edge_in);
        @(negedge clk);
        obs_shift  = int'(shift_enable);
        obs_byte   = int'(byte_received);
        obs_err    = int'(rx_error);
        obs_bitcnt = int'(bit_cnt);
        if (obs_shift == 1) strobe_log.push_back(cycle_no - seq_base);
        if (obs_byte == 1)  byte_log.push_back(cycle_no - seq_base);
        checkOutput("model shift_enable", obs_shift, modelShift());
        checkOutput("model byte_received", obs_byte, m_pend);
        checkOutput("model rx_error", obs_err, (m_state == 2) ? 1 : 0);
        checkOutput("model bit_cnt", obs_bitcnt, m_bits);
        enable_timer = en;
        d_edge       = edge_in;
        modelStep(en, edge_in);
        cycle_no++;
    endtask

    task automatic startSeq();
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        seq_base = cycle_no;
        strobe_log.delete();
        byte_log.delete();
    endtask

    task automatic setVec(input int i, input bit en, input bit e,
                          input int s, input int b, input int r, input int c);
        vecs[i].en         = en;
        vecs[i].edge_in    = e;
        vecs[i].exp_shift  = s;
        vecs[i].exp_byte   = b;
        vecs[i].exp_err    = r;
        vecs[i].exp_bitcnt = c;
    endtask

    int exp_q[$];
    int err_at_61, err_at_62, bitcnt_at_70;
    int gap, drop_left;
    bit r_en, r_edge;
    int n_before;

    initial begin
        // Expected outputs are those seen at the start of each row, before
        // that row's inputs are applied.
        setVec(0,  1'b0, 1'b0, 0, 0, 0, 0);
        setVec(1,  1'b1, 1'b0, 0, 0, 0, 0);
        setVec(2,  1'b1, 1'b1, 0, 0, 0, 0);
        setVec(3,  1'b1, 1'b0, 0, 0, 0, 0);
        setVec(4,  1'b1, 1'b0, 0, 0, 0, 0);
        setVec(5,  1'b1, 1'b1, 1, 0, 0, 0);
        setVec(6,  1'b1, 1'b0, 0, 0, 0, 1);
        setVec(7,  1'b1, 1'b0, 0, 0, 0, 1);
        setVec(8,  1'b1, 1'b0, RESYNC ? 1 : 0, 0, 0, 1);
        setVec(9,  1'b1, 1'b0, 0, 0, 0, RESYNC ? 2 : 1);
        setVec(10, 1'b1, 1'b0, 0, 0, 0, RESYNC ? 2 : 1);
        setVec(11, 1'b0, 1'b0, 0, 0, 0, RESYNC ? 2 : 1);
        setVec(12, 1'b1, 1'b0, 0, 0, 0, 0);
        setVec(13, 1'b1, 1'b0, 0, 0, 0, 0);

        n_rst        = 1'b0;
        enable_timer = 1'b0;
        d_edge       = 1'b0;
        resetModel();
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_rst = 1'b1;

        $display("[TB] vector table");
        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i].en, vecs[i].edge_in);
            checkOutput("vec shift_enable", obs_shift, vecs[i].exp_shift);
            checkOutput("vec byte_received", obs_byte, vecs[i].exp_byte);
            checkOutput("vec rx_error", obs_err, vecs[i].exp_err);
            checkOutput("vec bit_cnt", obs_bitcnt, vecs[i].exp_bitcnt);
        end

        $display("[TB] enabled without edges");
        startSeq();
        for (int k = 0; k < 50; k++) applyStimulus(1'b1, 1'b0);
        checkOutput("no-edge strobes", strobe_log.size(), 0);
        checkOutput("no-edge bytes", byte_log.size(), 0);

        $display("[TB] one byte at nominal rate");
        startSeq();
        bitcnt_at_70 = -1;
        for (int k = 0; k < 75; k++) begin
            applyStimulus(1'b1, (k >= 10 && k <= 66 && ((k - 10) % 8) == 0));
            if (k == 70) bitcnt_at_70 = obs_bitcnt;
        end
        exp_q.delete();
        for (int j = 0; j < 8; j++) exp_q.push_back(13 + 8 * j);
        checkLog("byte strobes", strobe_log, exp_q);
        exp_q.delete();
        exp_q.push_back(70);
        checkLog("byte_received", byte_log, exp_q);
        checkOutput("bit_cnt after byte", bitcnt_at_70, 0);

        $display("[TB] drifting 9-clock source");
        startSeq();
        for (int k = 0; k <= 52; k++)
            applyStimulus(1'b1, (k >= 2 && k <= 47 && ((k - 2) % 9) == 0));
        exp_q.delete();
        for (int j = 0; j < 6; j++)
            exp_q.push_back(RESYNC ? (5 + 9 * j) : (5 + 8 * j));
        checkLog("drift strobes", strobe_log, exp_q);

        $display("[TB] transition timeout");
        startSeq();
        err_at_61 = -1;
        err_at_62 = -1;
        for (int k = 0; k <= 72; k++) begin
            applyStimulus(1'b1, (k == 2));
            if (k == 61) err_at_61 = obs_err;
            if (k == 62) err_at_62 = obs_err;
        end
        exp_q.delete();
        for (int j = 0; j < 8; j++) exp_q.push_back(5 + 8 * j);
        checkLog("timeout strobes", strobe_log, exp_q);
        checkOutput("rx_error at 8th strobe", err_at_61, 0);
        checkOutput("rx_error after 8th strobe", err_at_62, 1);
        checkOutput("timeout bytes", byte_log.size(), 0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("rx_error while dropping", obs_err, 1);
        applyStimulus(1'b0, 1'b0);
        checkOutput("rx_error after drop", obs_err, 0);

        $display("[TB] reset mid-byte");
        startSeq();
        for (int k = 0; k <= 35; k++)
            applyStimulus(1'b1, (k >= 2 && ((k - 2) % 8) == 0));
        checkOutput("strobes before reset", strobe_log.size(), 4);
        #2;
        n_rst = 1'b0;
        #1;
        checkOutput("reset shift_enable", int'(shift_enable), 0);
        checkOutput("reset byte_received", int'(byte_received), 0);
        checkOutput("reset rx_error", int'(rx_error), 0);
        checkOutput("reset bit_cnt", int'(bit_cnt), 0);
        resetModel();
        for (int k = 0; k < 3; k++) applyStimulus(1'b1, 1'b0);
        n_rst = 1'b1;
        seq_base = cycle_no;
        strobe_log.delete();
        byte_log.delete();
        for (int k = 0; k < 20; k++) applyStimulus(1'b1, 1'b0);
        checkOutput("post-reset strobes", strobe_log.size(), 0);
        seq_base = cycle_no;
        strobe_log.delete();
        byte_log.delete();
        for (int k = 0; k <= 64; k++)
            applyStimulus(1'b1, (k >= 2 && k <= 58 && ((k - 2) % 8) == 0));
        exp_q.delete();
        exp_q.push_back(62);
        checkLog("post-reset byte", byte_log, exp_q);
        n_before = 0;
        foreach (strobe_log[i]) if (strobe_log[i] < 62) n_before++;
        checkOutput("strobes before byte", n_before, 8);

        $display("[TB] randomized traffic");
        startSeq();
        gap       = 0;
        drop_left = 0;
        for (int i = 0; i < 4000; i++) begin
            r_en   = 1'b1;
            r_edge = 1'b0;
            if (drop_left > 0) begin
                r_en = 1'b0;
                drop_left--;
            end else if ($urandom_range(0, 299) == 0) begin
                drop_left = $urandom_range(1, 3);
            end
            if (gap == 0) begin
                r_edge = 1'b1;
                gap = ($urandom_range(0, 19) == 0) ? $urandom_range(30, 90)
                                                   : $urandom_range(5, 10);
            end else begin
                gap--;
            end
            if ($urandom_range(0, 49) == 0) r_edge = 1'b1;
            applyStimulus(r_en, r_edge);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assert_count, fail_count);
        $finish;
    end

endmodule
